frame_stream_source: RTL and testbench

Avalon-ST video frame generator that drives the sink side of the frame filtering chain (frame averaging, blow-out correction). On a start request it emits one framed stream: a single SOP marker beat, FRAME_HEIGHT lines of FRAME_WIDTH pixel beats separated by programmable idle gaps, and a single EOP marker beat. It serves as the frame source for the filters and for bench/bring-up of the video path, with selectable test patterns and a continuous mode.

---
 rtl/frame_stream_source.sv | 122 ++++++++++++
 tb/tb_frame_stream_source.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/frame_stream_source.sv
// frame_stream_source: Avalon-ST framed test-pattern source (SOP beat, lines of pixels with gaps, EOP beat)
// Ports: clk rising-edge clock; reset async active-low; en freezes progress when low;
//   start frame request (IDLE only); continuous auto-restart after FRAME_GAP;
//   pattern_sel/pattern_value pattern choice, latched at frame start;
//   source_valid/sop/eop/data output beats; busy high outside IDLE; frame_count completed frames.
module frame_stream_source #(
   parameter int DATA_WIDTH   = 16,
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 10,
   parameter int LINE_GAP     = 16,
   parameter int FRAME_GAP    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  start,
   input  logic                  continuous,
   input  logic [1:0]            pattern_sel,
   input  logic [DATA_WIDTH-1:0] pattern_value,
   output logic                  source_valid,
   output logic                  source_sop,
   output logic                  source_eop,
   output logic [DATA_WIDTH-1:0] source_data,
   output logic                  busy,
   output logic [7:0]            frame_count
);
   typedef enum logic [2:0] {IDLE, SOP, LINE, GAP, EOP, FGAP} state_t;
   localparam logic [15:0] W_LAST  = 16'(FRAME_WIDTH - 1);
   localparam logic [15:0] H_LAST  = 16'(FRAME_HEIGHT - 1);
   localparam logic [15:0] LG_LAST = 16'(LINE_GAP - 1);
   localparam logic [15:0] FG_LAST = 16'(FRAME_GAP - 1);
   state_t state, ns;
   logic [15:0] pix, line, gap, np, nl, ng;
   logic [7:0] nfc;
   logic [1:0] sel_q;
   logic [DATA_WIDTH-1:0] val_q, pix_val;
   logic [31:0] ramp;
   logic line_last, latch;
   assign line_last = line == H_LAST;
   // counters always describe the beat currently on the outputs; en=0 simply skips the advance
   always_comb begin
      ns  = state;
      np  = pix;
      nl  = line;
      ng  = gap;
      nfc = frame_count;
      if (en)
         case (state)
            IDLE: if (start) ns = SOP;
            SOP: begin
               ns = LINE;
               np = '0;
               nl = '0;
            end
            LINE:
               if (pix != W_LAST) np = pix + 16'd1;
               else if (LINE_GAP > 0) begin
                  ns = GAP;
                  ng = '0;
               end else if (!line_last) begin
                  np = '0;
                  nl = line + 16'd1;
               end else begin
                  ns  = EOP;
                  nfc = frame_count + 8'd1;
               end
            GAP:
               if (gap != LG_LAST) ng = gap + 16'd1;
               else if (!line_last) begin
                  ns = LINE;
                  np = '0;
                  nl = line + 16'd1;
               end else begin
                  ns  = EOP;
                  nfc = frame_count + 8'd1;
               end
            EOP: begin
               ns = !continuous ? IDLE : (FRAME_GAP > 0) ? FGAP : SOP;
               ng = '0;
            end
            FGAP:
               if (gap != FG_LAST) ng = gap + 16'd1;
               else ns = SOP;
            default: ns = IDLE;
         endcase
   end
   // pattern is captured once on entry to SOP so mid-frame changes cannot leak into the frame
   assign latch   = en && ns == SOP && state != SOP;
   assign ramp    = {16'd0, frame_count, 8'd0} + {16'd0, np};
   assign pix_val = sel_q == 2'd0 ? DATA_WIDTH'(np) :
                    sel_q == 2'd1 ? DATA_WIDTH'(nl) :
                    sel_q == 2'd2 ? DATA_WIDTH'(ramp) : val_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pix          <= '0;
         line         <= '0;
         gap          <= '0;
         frame_count  <= '0;
         sel_q        <= '0;
         val_q        <= '0;
         source_valid <= 1'b0;
         source_sop   <= 1'b0;
         source_eop   <= 1'b0;
         source_data  <= '0;
         busy         <= 1'b0;
      end else begin
         state        <= ns;
         pix          <= np;
         line         <= nl;
         gap          <= ng;
         frame_count  <= nfc;
         sel_q        <= latch ? pattern_sel : sel_q;
         val_q        <= latch ? pattern_value : val_q;
         source_valid <= en && (ns == SOP || ns == LINE || ns == EOP);
         source_sop   <= en && ns == SOP;
         source_eop   <= en && ns == EOP;
         source_data  <= (en && ns == LINE) ? pix_val : '0;
         busy         <= ns != IDLE;
      end
   end
endmodule

// File: tb/tb_frame_stream_source.sv
// tb_frame_stream_source: scoreboard bench, per-cycle expected beats queued by stimulus and popped by a monitor
module tb_frame_stream_source;
   typedef struct packed {logic v; logic s; logic e; logic [15:0] d;} beat_t;
   logic clk = 0;
   always #5 clk = ~clk;
   logic reset = 0;
   logic en0 = 1, start0 = 0, cont0 = 0, en1 = 1, start1 = 0, cont1 = 0;
   logic [1:0] sel0 = 0, sel1 = 0;
   logic [15:0] val0 = 0, val1 = 0;
   logic v0, s0, e0, b0, v1, s1, e1, b1;
   logic [15:0] d0, d1;
   logic [7:0] fc0, fc1;
   int passed = 0, total = 0;
   beat_t q0[$], q1[$];
   beat_t x0, x1;

   frame_stream_source #(.DATA_WIDTH(16), .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .LINE_GAP(2), .FRAME_GAP(3)) u0 (
      .clk(clk), .reset(reset), .en(en0), .start(start0), .continuous(cont0),
      .pattern_sel(sel0), .pattern_value(val0), .source_valid(v0), .source_sop(s0),
      .source_eop(e0), .source_data(d0), .busy(b0), .frame_count(fc0));
   frame_stream_source #(.DATA_WIDTH(16), .FRAME_WIDTH(3), .FRAME_HEIGHT(3), .LINE_GAP(0), .FRAME_GAP(0)) u1 (
      .clk(clk), .reset(reset), .en(en1), .start(start1), .continuous(cont1),
      .pattern_sel(sel1), .pattern_value(val1), .source_valid(v1), .source_sop(s1),
      .source_eop(e1), .source_data(d1), .busy(b1), .frame_count(fc1));

   task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
   endtask

   task automatic put(input int d, input beat_t b);
      if (d == 0) q0.push_back(b);
      else q1.push_back(b);
   endtask

   task automatic idle(input int d, input int n);
      for (int i = 0; i < n; i++) put(d, '0);
   endtask

   task automatic gen(input int d, input int w, input int h, input int lg, input int pat,
                      input logic [15:0] val, input int fc);
      logic [15:0] x;
      put(d, {3'b110, 16'h0});
      for (int l = 0; l < h; l++) begin
         for (int p = 0; p < w; p++) begin
            x = pat == 0 ? 16'(p) : pat == 1 ? 16'(l) : pat == 2 ? 16'(fc * 256 + p) : val;
            put(d, {3'b100, x});
         end
         idle(d, lg);
      end
      put(d, {3'b101, 16'h0});
   endtask

   function automatic int qsize(input int d);
      return d == 0 ? q0.size() : q1.size();
   endfunction

   task automatic drain(input int d);
      int n = 0;
      while (qsize(d) != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (qsize(d) != 0) begin
         cmp($sformatf("drain timeout u%0d", d), qsize(d), 0);
         if (d == 0) q0.delete();
         else q1.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_below(input int d, input int lim);
      int n = 0;
      while (qsize(d) > lim && n < 20000) begin
         @(negedge clk);
         n++;
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (q0.size() != 0) begin
         x0 = q0.pop_front();
         cmp("u0 beat", {v0, s0, e0, d0}, x0);
      end else cmp("u0 idle", {v0, s0, e0, d0}, 0);
      if (q1.size() != 0) begin
         x1 = q1.pop_front();
         cmp("u1 beat", {v1, s1, e1, d1}, x1);
      end else cmp("u1 idle", {v1, s1, e1, d1}, 0);
   end

   initial begin
      repeat (3) @(negedge clk);
      cmp("reset outs u0", {v0, s0, e0, d0, b0, fc0}, 0);
      cmp("reset outs u1", {v1, s1, e1, d1, b1, fc1}, 0);
      reset = 1;
      @(negedge clk);
      // basic frame, horizontal ramp
      sel0 = 0; start0 = 1; gen(0, 4, 2, 2, 0, 0, 0);
      @(negedge clk); start0 = 0;
      cmp("t1 busy high", b0, 1);
      drain(0);
      cmp("t1 busy low", b0, 0);
      cmp("t1 frame_count", fc0, 1);
      // constant pattern held across mid-frame changes
      sel0 = 3; val0 = 16'hA5A5; start0 = 1; gen(0, 4, 2, 2, 3, 16'hA5A5, 1);
      @(negedge clk); start0 = 0;
      repeat (3) @(negedge clk);
      sel0 = 2; val0 = 16'h1234;
      drain(0);
      sel0 = 3; start0 = 1; gen(0, 4, 2, 2, 3, 16'h1234, 2);
      @(negedge clk); start0 = 0;
      drain(0);
      cmp("t2 frame_count", fc0, 3);
      // en dropped for 5 cycles after pixel 1, start during frame ignored
      sel0 = 0; start0 = 1; gen(0, 4, 2, 2, 0, 0, 3);
      for (int i = 0; i < 5; i++) q0.insert(3, '0);
      @(negedge clk); start0 = 0;
      @(negedge clk);
      @(negedge clk); en0 = 0; start0 = 1;
      repeat (5) @(negedge clk);
      en0 = 1; start0 = 0;
      drain(0);
      repeat (3) @(negedge clk);
      cmp("t3 frame_count", fc0, 4);
      cmp("t3 busy low", b0, 0);
      // continuous frame+pixel ramp across frame_count wrap
      sel0 = 2; cont0 = 1; start0 = 1;
      for (int k = 0; k < 254; k++) begin
         gen(0, 4, 2, 2, 2, 0, (4 + k) % 256);
         if (k < 253) idle(0, 3);
      end
      @(negedge clk); start0 = 0;
      wait_below(0, 10);
      cont0 = 0;
      drain(0);
      cmp("t4 frame_count wrap", fc0, 2);
      cmp("t4 busy low", b0, 0);
      // zero line gap, vertical ramp
      sel1 = 1; start1 = 1; gen(1, 3, 3, 0, 1, 0, 0);
      @(negedge clk); start1 = 0;
      drain(1);
      cmp("t5 frame_count", fc1, 1);
      cmp("t5 busy low", b1, 0);
      // continuous with zero frame gap: SOP directly after EOP
      sel1 = 2; cont1 = 1; start1 = 1;
      gen(1, 3, 3, 0, 2, 0, 1);
      gen(1, 3, 3, 0, 2, 0, 2);
      @(negedge clk); start1 = 0;
      wait_below(1, 8);
      cont1 = 0;
      drain(1);
      cmp("t6 frame_count", fc1, 3);
      // reset during the gap after line 1 aborts with no EOP
      sel0 = 0; start0 = 1; gen(0, 4, 2, 2, 0, 0, 2);
      @(negedge clk); start0 = 0;
      repeat (11) @(negedge clk);
      reset = 0;
      q0.delete();
      #1;
      cmp("t7 abort outs", {v0, s0, e0, d0, b0}, 0);
      cmp("t7 abort fc u0", fc0, 0);
      cmp("t7 abort fc u1", fc1, 0);
      @(negedge clk); reset = 1;
      @(negedge clk);
      start0 = 1; gen(0, 4, 2, 2, 0, 0, 0);
      @(negedge clk); start0 = 0;
      drain(0);
      cmp("t7 restart frame_count", fc0, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
